l2_line_responder: RTL and testbench

- Line-granular, direct-mapped, write-back L2 cache.
- Acts as the responder for the arbiter's L2-side line request port (read, write, 16-bit address, 128-bit line data, resp).
- Serves hits locally. On a miss it acts as initiator toward physical memory over an identical line protocol (write back the victim, then fetch the line).
- Sits between the L1 arbiter and main memory.

---
 rtl/l2_line_responder.sv | 179 +++++++++++++++++
 tb/tb_l2_line_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_responder.sv
// Direct-mapped, write-back line cache between the L1 arbiter and physical memory.
// Optional perf counters (hit_count/miss_count) are built when L2_PERF_COUNTERS_EN is defined.
module l2_line_responder #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_read,
  input  logic         up_write,
  input  logic [15:0]  up_address,
  input  logic [127:0] up_wdata,
  output logic         up_resp,
  output logic [127:0] up_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
`ifdef L2_PERF_COUNTERS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int          TAG_BITS  = 16 - OFFSET_BITS - INDEX_BITS;
  localparam int          NUM_SETS  = 1 << INDEX_BITS;
  localparam logic [15:0] LINE_MASK = ~16'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t r_state;

  logic                r_valid [NUM_SETS];
  logic                r_dirty [NUM_SETS];
  logic [TAG_BITS-1:0] r_tag   [NUM_SETS];
  logic [127:0]        r_data  [NUM_SETS];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_is_read;
  logic                  w_hit;
  logic                  w_victim_dirty;
  logic                  w_clean_wmiss;
  logic                  w_resp;
  logic                  w_line_we;
  logic [127:0]          w_line_wdata;
  logic                  w_line_dirty;
  logic                  w_dirty_clr;

  assign w_index        = up_address[OFFSET_BITS +: INDEX_BITS];
  assign w_tag          = up_address[15 -: TAG_BITS];
  // A simultaneous read+write request is served as a read.
  assign w_is_read      = up_read;
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_clean_wmiss  = !w_hit && !w_victim_dirty && !w_is_read;
  assign w_resp         = (r_state == S_CHECK) && (w_hit || w_clean_wmiss);

  assign up_resp  = w_resp;
  assign up_rdata = (w_resp && w_is_read) ? r_data[w_index] : '0;

  assign pmem_write = (r_state == S_WRITEBACK);
  assign pmem_read  = (r_state == S_ALLOCATE);
  assign pmem_wdata = (r_state == S_WRITEBACK) ? r_data[w_index] : '0;

  always_comb begin
    pmem_address = '0;
    case (r_state)
      S_WRITEBACK: pmem_address = {r_tag[w_index], w_index, {OFFSET_BITS{1'b0}}};
      S_ALLOCATE:  pmem_address = up_address & LINE_MASK;
      default:     pmem_address = '0;
    endcase
  end

  // Line install: write hit or clean-victim write miss, or refill from memory.
  always_comb begin
    w_line_we    = 1'b0;
    w_line_wdata = '0;
    w_line_dirty = 1'b0;
    w_dirty_clr  = 1'b0;
    case (r_state)
      S_CHECK: begin
        if (!w_is_read && (w_hit || w_clean_wmiss)) begin
          w_line_we    = 1'b1;
          w_line_wdata = up_wdata;
          w_line_dirty = 1'b1;
        end
      end
      S_ALLOCATE: begin
        if (pmem_resp) begin
          w_line_we    = 1'b1;
          w_line_wdata = pmem_rdata;
        end
      end
      S_WRITEBACK: w_dirty_clr = pmem_resp;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (w_line_we) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= w_line_dirty;
      r_tag[w_index]   <= w_tag;
      r_data[w_index]  <= w_line_wdata;
    end else if (w_dirty_clr) begin
      r_dirty[w_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (up_read || up_write) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_hit)               r_state <= S_IDLE;
          else if (w_victim_dirty) r_state <= S_WRITEBACK;
          else if (w_is_read)      r_state <= S_ALLOCATE;
          else                     r_state <= S_IDLE;
        end
        S_WRITEBACK: begin
          // A write returns to CHECK, where it now installs as a clean-victim miss.
          if (pmem_resp) r_state <= w_is_read ? S_ALLOCATE : S_CHECK;
        end
        S_ALLOCATE: begin
          if (pmem_resp) r_state <= S_CHECK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_PERF_COUNTERS_EN
  logic        r_first_look;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // The re-CHECK after a refill hits by construction and is not a real hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_look <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_state == S_IDLE && (up_read || up_write)) r_first_look <= 1'b1;
      if (r_state == S_ALLOCATE && pmem_resp)         r_first_look <= 1'b0;
      if (r_state == S_CHECK) begin
        if (w_hit && r_first_look && r_hit_count != 16'hFFFF)
          r_hit_count <= r_hit_count + 16'd1;
        if (!w_hit && r_miss_count != 16'hFFFF)
          r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: expected up/pmem transactions are queued by the
// driver and checked by independent monitors; a small memory model answers pmem requests.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_read, up_write;
  logic [15:0]  up_address;
  logic [127:0] up_wdata;
  logic         up_resp;
  logic [127:0] up_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
`ifdef L2_PERF_COUNTERS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  l2_line_responder dut (
    .clk(clk), .rst(rst),
    .up_read(up_read), .up_write(up_write), .up_address(up_address), .up_wdata(up_wdata),
    .up_resp(up_resp), .up_rdata(up_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef L2_PERF_COUNTERS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] LA = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] LW = 128'hDEADBEEF0000111122223333CAFEF00D;
  localparam logic [127:0] LB = 128'h5A5A5A5A123412340F0F0F0FA5A5A5A5;
  localparam logic [127:0] LX = 128'h7F7F7F7F11112222333344445555AAAA;
  localparam logic [127:0] LY = 128'h0F0F0F0FBBBBCCCCDDDDEEEE99998888;
  localparam logic [127:0] LC = 128'h22502250FFFF0000AAAA5555C3C3C3C3;

  typedef struct packed {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } pm_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] up_q [$];
  pm_t          pm_q [$];
  logic [127:0] mem [logic [15:0]];
  int           mem_lat  = 2;
  int           mem_cnt  = 0;
  bit           txn_open = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Upstream monitor: every up_resp consumes one expected line.
  always @(negedge clk) begin : up_mon
    logic [127:0] e;
    if (up_resp) begin
      if (up_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_up_resp: got up_resp=1 rdata=%h, required none", up_rdata);
      end else begin
        e = up_q.pop_front();
        chk("up_rdata", up_rdata, e);
        $display("[TB] up_resp addr=%h rdata=%h", up_address, up_rdata);
      end
    end else begin
      chk("up_rdata_idle", up_rdata, '0);
    end
  end

  // Memory model plus pmem monitor: each new request is checked against the queue.
  always @(negedge clk) begin : pm_proc
    pm_t e;
    if (pmem_read && pmem_write) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL pmem_onehot: got read=1 write=1, required at most one");
    end
    if (!(pmem_read || pmem_write)) begin
      txn_open  = 1'b0;
      mem_cnt   = 0;
      pmem_resp = 1'b0;
    end else begin
      if (!txn_open) begin
        txn_open = 1'b1;
        mem_cnt  = 0;
        $display("[TB] pmem %s addr=%h wdata=%h", pmem_write ? "write" : "read", pmem_address, pmem_wdata);
        if (pm_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_pmem: got write=%b addr=%h, required none", pmem_write, pmem_address);
        end else begin
          e = pm_q.pop_front();
          chk("pmem_is_write", 128'(pmem_write), 128'(e.wr));
          chk("pmem_address", 128'(pmem_address), 128'(e.addr));
          if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
        end
      end
      if (mem_cnt >= mem_lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) mem[pmem_address] = pmem_wdata;
        else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : '0;
        txn_open = 1'b0;
        mem_cnt  = 0;
      end else begin
        pmem_resp = 1'b0;
        mem_cnt++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    up_read = 1'b0;
    up_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the request withdrawn.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd, input int exp_lat);
    int cyc;
    bit got;
    up_read    = !wr;
    up_write   = wr;
    up_address = addr;
    up_wdata   = wd;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (up_resp) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL up_resp_timeout: got no up_resp in %0d cycles for addr=%h, required one", cyc, addr);
    end else if (exp_lat > 0) begin
      chk("hit_latency", 128'(cyc), 128'(exp_lat));
    end
    @(posedge clk);
    #1;
    up_read  = 1'b0;
    up_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("up_q_drained", 128'(up_q.size()), 128'(0));
    chk("pm_q_drained", 128'(pm_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    up_address = '0;
    up_wdata   = '0;
    do_reset();

    @(negedge clk);
    chk("rst_up_resp", 128'(up_resp), 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    @(posedge clk);
    #1;

    // Read miss, then offset-only variant hits the same line.
    mem[16'h1230] = LA;
    pm_q.push_back('{1'b0, 16'h1230, 128'h0});
    up_q.push_back(LA);
    do_req(1'b0, 16'h1230, '0, 0);
    up_q.push_back(LA);
    do_req(1'b0, 16'h123E, '0, 2);

    // Write hit, then a conflicting read forces writeback then fetch.
    up_q.push_back('0);
    do_req(1'b1, 16'h1230, LW, 2);
    mem[16'h5230] = LB;
    pm_q.push_back('{1'b1, 16'h1230, LW});
    pm_q.push_back('{1'b0, 16'h5230, 128'h0});
    up_q.push_back(LB);
    do_req(1'b0, 16'h5230, '0, 0);
    chk("mem_after_wb", mem[16'h1230], LW);

    // Clean victim: refetch 0x1230 returns the written-back line.
    pm_q.push_back('{1'b0, 16'h1230, 128'h0});
    up_q.push_back(LW);
    do_req(1'b0, 16'h1230, '0, 0);

    // Clean write miss installs with no pmem traffic; then a dirty write miss.
    do_reset();
    up_q.push_back('0);
    do_req(1'b1, 16'h7F40, LX, 2);
    up_q.push_back(LX);
    do_req(1'b0, 16'h7F40, '0, 2);
    pm_q.push_back('{1'b1, 16'h7F40, LX});
    up_q.push_back('0);
    do_req(1'b1, 16'h0F40, LY, 0);
    up_q.push_back(LY);
    do_req(1'b0, 16'h0F40, '0, 2);

    // Reset while ALLOCATE is waiting on memory.
    mem_lat = 20;
    mem[16'h2250] = LC;
    pm_q.push_back('{1'b0, 16'h2250, 128'h0});
    up_read    = 1'b1;
    up_address = 16'h2250;
    cyc = 0;
    while (!pmem_read && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("alloc_reached", 128'(pmem_read), 128'(1));
    @(posedge clk);
    #1;
    rst     = 1'b1;
    up_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("pmem_read_after_rst", 128'(pmem_read), 128'(0));
    @(posedge clk);
    #1;
    mem_lat = 2;
    pm_q.push_back('{1'b0, 16'h2250, 128'h0});
    up_q.push_back(LC);
    do_req(1'b0, 16'h2250, '0, 0);

`ifdef L2_PERF_COUNTERS_EN
    do_reset();
    mem[16'h1230] = LA;
    pm_q.push_back('{1'b0, 16'h1230, 128'h0});
    up_q.push_back(LA);
    do_req(1'b0, 16'h1230, '0, 0);
    up_q.push_back(LA);
    do_req(1'b0, 16'h1230, '0, 2);
    up_q.push_back(LA);
    do_req(1'b0, 16'h1234, '0, 2);
    @(negedge clk);
    chk("hit_count", 128'(hit_count), 128'(2));
    chk("miss_count", 128'(miss_count), 128'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
